// File: rtl/present80_dec_ks_if.sv
// Round-key handshake bundle between the PRESENT-80 decryption key schedule
// and its consumer; the key schedule uses the slave modport.
interface present80_dec_ks_if;
  logic        start;
  logic [0:79] key;
  logic        busy;
  logic        rk_vld;
  logic        rk_rdy;
  logic [0:63] rk;
  logic [0:5]  rk_num;
  logic        done;

  modport slave (
    input  start, key, rk_rdy,
    output busy, rk_vld, rk, rk_num, done
  );

  modport master (
    output start, key, rk_rdy,
    input  busy, rk_vld, rk, rk_num, done
  );
endinterface

// File: rtl/present80_dec_ks.sv
// PRESENT-80 decryption key schedule: runs the forward update to the last key
// state, then unwinds it with the inverse update, emitting K32 down to K1.
module present80_dec_ks #(
  parameter int NUPD = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  present80_dec_ks_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;

  localparam logic [4:0] CNT_LAST  = 5'(NUPD);
  localparam logic [5:0] NUM_FIRST = 6'(NUPD + 1);

  state_t      state_q, state_d;
  logic [0:79] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  num_q, num_d;
  logic        done_q, done_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // Bit 0 is the MSB throughout; the rotation is the usual left-by-61.
  function automatic logic [0:79] f_upd(input logic [0:79] k, input logic [4:0] c);
    logic [0:79] r;
    r        = {k[61:79], k[0:60]};
    r[0:3]   = sbox(r[0:3]);
    r[60:64] = r[60:64] ^ c;
    return r;
  endfunction

  // Exact inverse of f_upd for the same counter value.
  function automatic logic [0:79] g_upd(input logic [0:79] k, input logic [4:0] c);
    logic [0:79] t;
    t        = k;
    t[60:64] = t[60:64] ^ c;
    t[0:3]   = sbox_inv(t[0:3]);
    return {t[19:79], t[0:18]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          cnt_d   = 5'd1;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = f_upd(key_q, cnt_q);
        if (cnt_q == CNT_LAST) begin
          state_d = OUT;
          num_d   = NUM_FIRST;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      OUT: begin
        if (bus.rk_rdy) begin
          // K1 is the master key itself, so the last handshake leaves the register alone.
          if (num_q == 6'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            num_d   = '0;
          end else begin
            key_d = g_upd(key_q, cnt_q);
            cnt_d = cnt_q - 5'd1;
            num_d = num_q - 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.rk_vld = (state_q == OUT);
  assign bus.rk     = key_q[0:63];
  assign bus.rk_num = num_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_present80_dec_ks.sv
// Self-checking bench for present80_dec_ks against a forward-schedule model
// built with plain 80-bit shift/mask arithmetic.
module tb_present80_dec_ks;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  present80_dec_ks_if ifc();

  present80_dec_ks #(.NUPD(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int sbox_tbl[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  logic [63:0] sched[32];
  logic [63:0] last_rk, prev_rk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] fwd(input logic [79:0] k, input int c);
    logic [79:0] r;
    r = (k << 61) | (k >> 19);
    r = (r & ~(80'hF << 76)) | (80'(sbox_tbl[r[79:76]]) << 76);
    r = r ^ (80'(c) << 15);
    return r;
  endfunction

  // sched[i] is round key K(i+1): top 64 bits after i forward updates.
  task automatic build(input logic [79:0] k);
    logic [79:0] s;
    s = k;
    for (int i = 0; i < 32; i++) begin
      sched[i] = s[79:16];
      if (i < 31) s = fwd(s, i + 1);
    end
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},   80'(ifc.busy),   80'd0);
    check({tag, ".rk_vld"}, 80'(ifc.rk_vld), 80'd0);
    check({tag, ".rk"},     80'(ifc.rk),     80'd0);
    check({tag, ".rk_num"}, 80'(ifc.rk_num), 80'd0);
    check({tag, ".done"},   80'(ifc.done),   80'd0);
  endtask

  task automatic start_key(input logic [79:0] k);
    ifc.start = 1'b1;
    ifc.key   = k;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.key   = rand_key();
  endtask

  // Called one sample after the start edge; consumes all 32 keys.
  task automatic drain(input string tag, input logic [79:0] k, input bit rnd,
                       input int p1, input int p2, input bit b2b, input logic [79:0] k2);
    int cyc, idx;
    bit stall, fin, last_acc, rdy;
    logic [63:0] hold_rk;
    logic [5:0]  hold_num;
    build(k);
    cyc = 0; idx = 0; stall = 0; fin = 0; last_acc = 0;
    hold_rk = '0; hold_num = '0;
    check({tag, ".busy_after_start"}, 80'(ifc.busy), 80'd1);
    while (cyc < 400 && !fin) begin
      ifc.start = (cyc == p1 || cyc == p2);
      if (ifc.start) ifc.key = rand_key();
      if (cyc == 30) check({tag, ".vld_c30"}, 80'(ifc.rk_vld), 80'd0);
      if (cyc == 31) check({tag, ".vld_c31"}, 80'(ifc.rk_vld), 80'd1);
      if (stall) begin
        check({tag, ".stall_rk"},  80'(ifc.rk),     80'(hold_rk));
        check({tag, ".stall_num"}, 80'(ifc.rk_num), 80'(hold_num));
      end
      if (last_acc) begin
        check({tag, ".done_pulse"}, 80'(ifc.done),   80'd1);
        check({tag, ".busy_end"},   80'(ifc.busy),   80'd0);
        check({tag, ".vld_end"},    80'(ifc.rk_vld), 80'd0);
        fin = 1;
        if (b2b) begin
          ifc.start = 1'b1;
          ifc.key   = k2;
        end
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ifc.rk_rdy = rdy;
        if (ifc.rk_vld && rdy) begin
          check({tag, ".rk"},     80'(ifc.rk),     80'(sched[31 - idx]));
          check({tag, ".rk_num"}, 80'(ifc.rk_num), 80'(32 - idx));
          prev_rk = last_rk;
          last_rk = ifc.rk;
          if (ifc.rk_num == 6'd1) last_acc = 1;
          idx++;
        end
        stall    = ifc.rk_vld && !rdy;
        hold_rk  = ifc.rk;
        hold_num = ifc.rk_num;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) check({tag, ".timeout"}, 80'(fin), 80'd1);
    check({tag, ".key_count"}, 80'(idx), 80'd32);
    if (!b2b) begin
      ifc.start = 1'b0;
      @(posedge clk); #1;
      check({tag, ".done_once"}, 80'(ifc.done), 80'd0);
      check({tag, ".idle"},      80'(ifc.busy), 80'd0);
    end
  endtask

  initial begin
    logic [79:0] ka, kb;
    int guard;
    ifc.start  = 1'b0;
    ifc.key    = '0;
    ifc.rk_rdy = 1'b0;
    last_rk    = '0;
    prev_rk    = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero key with continuous ready.
    start_key(80'd0);
    drain("zero", 80'd0, 1'b0, -1, -1, 1'b0, 80'd0);
    check("zero.k2", 80'(prev_rk), 80'h0000_C000000000000000);
    check("zero.k1", 80'(last_rk), 80'd0);

    // All-ones key.
    start_key({80{1'b1}});
    drain("ones", {80{1'b1}}, 1'b0, -1, -1, 1'b0, 80'd0);
    check("ones.k1", 80'(last_rk), 80'h0000_FFFFFFFFFFFFFFFF);

    // Random keys with random backpressure.
    for (int n = 0; n < 3; n++) begin
      ka = rand_key();
      start_key(ka);
      drain("rand", ka, 1'b1, -1, -1, 1'b0, 80'd0);
    end

    // Spurious start during FWD and during OUT.
    ka = rand_key();
    start_key(ka);
    drain("spur", ka, 1'b1, 10, 40, 1'b0, 80'd0);

    // Reset in the middle of FWD.
    ifc.rk_rdy = 1'b1;
    start_key(rand_key());
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_fwd");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_fwd_rel");
    ka = rand_key();
    start_key(ka);
    drain("after_rst_fwd", ka, 1'b0, -1, -1, 1'b0, 80'd0);

    // Reset in the middle of OUT at rk_num 17.
    ifc.rk_rdy = 1'b1;
    start_key(rand_key());
    guard = 0;
    while (!(ifc.rk_vld && ifc.rk_num == 6'd17) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rst_out.reached", 80'(ifc.rk_num), 80'd17);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_out");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_out_rel");
    ka = rand_key();
    start_key(ka);
    drain("after_rst_out", ka, 1'b1, -1, -1, 1'b0, 80'd0);

    // Back-to-back: new start in the done cycle.
    ka = rand_key();
    kb = rand_key();
    start_key(ka);
    drain("b2b_a", ka, 1'b0, -1, -1, 1'b1, kb);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.key   = rand_key();
    drain("b2b_b", kb, 1'b1, -1, -1, 1'b0, 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
